// File: rtl/pipe_pkg.sv
// Shared types for the write-back pipeline: stall-bus codes and the per-lane
// write-back record layout {addr, write, data}.
package pipe_pkg;

  localparam int STALL_W    = 2;
  localparam int WB_XLEN    = 32;
  localparam int WB_RADDR_W = 5;

  typedef enum logic [STALL_W-1:0] {
    STALL_PASS = 2'b00,
    STALL_HOLD = 2'b01,
    STALL_BUBB = 2'b10
  } stall_e;

  typedef struct packed {
    logic [WB_RADDR_W-1:0] addr;
    logic                  write;
    logic [WB_XLEN-1:0]    data;
  } wb_rec_t;

  // Width of one packed lane record for arbitrary widths.
  function automatic int rec_width(input int raddr_w, input int xlen);
    return raddr_w + 1 + xlen;
  endfunction

endpackage

// File: rtl/wb_skid2.sv
// Generic 2-entry circular skid buffer. The caller guarantees push only when
// not full and pop only when not empty; flush empties and clears all storage.
module wb_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_ent0,
  output logic [W-1:0] o_ent1,
  output logic         o_head_ptr,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_count;

  // Storage, pointers and occupancy; flush has priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        if (r_tail) begin
          r_ent1 <= i_data;
        end else begin
          r_ent0 <= i_data;
        end
        r_tail <= ~r_tail;
      end
      if (i_pop) begin
        r_head <= ~r_head;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_ent0     = r_ent0;
  assign o_ent1     = r_ent1;
  assign o_head_ptr = r_head;
  assign o_count    = r_count;

endmodule

// File: rtl/reg_wb_pipe.sv
// MEM/WB pipeline register: LANES write-back records behind a 2-entry skid
// buffer with stall-bus priority. Define REG_WB_PIPE_FWD_EN for forwarding lookup.
module reg_wb_pipe
  import pipe_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*RADDR_W-1:0] rd_addr_i,
  input  logic [LANES-1:0]         rd_write_i,
  input  logic [LANES*XLEN-1:0]    rd_data_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*RADDR_W-1:0] rd_addr_o,
  output logic [LANES-1:0]         rd_write_o,
  output logic [LANES*XLEN-1:0]    rd_data_o,
  output logic [1:0]               occupancy
`ifdef REG_WB_PIPE_FWD_EN
  ,
  input  logic [LANES*RADDR_W-1:0] fwd_addr_i,
  output logic [LANES-1:0]         fwd_hit_o,
  output logic [LANES*XLEN-1:0]    fwd_data_o
`endif
);

  localparam int REC_W = rec_width(RADDR_W, XLEN);
  localparam int PAY_W = LANES * REC_W;

  logic             w_pass;
  logic             w_bubb;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [PAY_W-1:0] w_pay_in;
  logic [PAY_W-1:0] w_ent0;
  logic [PAY_W-1:0] w_ent1;
  logic [PAY_W-1:0] w_head;
  logic [PAY_W-1:0] w_head_q;
  logic             w_head_ptr;
  logic [1:0]       w_count;

  // Anything that is neither Pass nor Bubb behaves as Hold: no push, no pop.
  assign w_pass      = (stall == STALL_PASS);
  assign w_bubb      = (stall == STALL_BUBB);
  assign w_in_ready  = (w_count != 2'd2) && w_pass;
  assign w_out_valid = (w_count != 2'd0) && !w_bubb;
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready && w_pass;

  // Pack incoming lanes; x0 destinations are stored as write=0, data=0.
  always_comb begin
    w_pay_in = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pay_in[l*REC_W + XLEN + 1 +: RADDR_W] = rd_addr_i[l*RADDR_W +: RADDR_W];
      w_pay_in[l*REC_W + XLEN] = rd_write_i[l] && (rd_addr_i[l*RADDR_W +: RADDR_W] != '0);
      w_pay_in[l*REC_W +: XLEN] = (rd_addr_i[l*RADDR_W +: RADDR_W] != '0) ?
                                  rd_data_i[l*XLEN +: XLEN] : '0;
    end
  end

  wb_skid2 #(
    .W (PAY_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_bubb),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_data     (w_pay_in),
    .o_ent0     (w_ent0),
    .o_ent1     (w_ent1),
    .o_head_ptr (w_head_ptr),
    .o_count    (w_count)
  );

  // Popped entries keep stale contents, so an empty buffer must present zeros.
  assign w_head   = w_head_ptr ? w_ent1 : w_ent0;
  assign w_head_q = (w_count != 2'd0) ? w_head : '0;

  // Unpack the head record onto the lane-packed output buses.
  always_comb begin
    rd_addr_o  = '0;
    rd_write_o = '0;
    rd_data_o  = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_addr_o[l*RADDR_W +: RADDR_W] = w_head_q[l*REC_W + XLEN + 1 +: RADDR_W];
      rd_write_o[l]                   = w_head_q[l*REC_W + XLEN];
      rd_data_o[l*XLEN +: XLEN]       = w_head_q[l*REC_W +: XLEN];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign occupancy = w_count;

`ifdef REG_WB_PIPE_FWD_EN
  logic             w_newest_ptr;
  logic [PAY_W-1:0] w_newest;

  // With two entries the newest sits opposite the head; with one it is the head.
  assign w_newest_ptr = w_head_ptr ^ (w_count == 2'd2);
  assign w_newest     = w_newest_ptr ? w_ent1 : w_ent0;

  // Newest entry first, then higher lanes first; the first live match wins.
  always_comb begin
    logic             w_found;
    logic             w_match;
    logic             w_ent_live;
    logic [REC_W-1:0] w_rec;
    logic [RADDR_W-1:0] w_qa;
    fwd_hit_o  = '0;
    fwd_data_o = '0;
    w_found    = 1'b0;
    w_match    = 1'b0;
    w_ent_live = 1'b0;
    w_rec      = '0;
    w_qa       = '0;
    for (int q = 0; q < LANES; q++) begin
      w_found = 1'b0;
      w_qa    = fwd_addr_i[q*RADDR_W +: RADDR_W];
      for (int e = 0; e < 2; e++) begin
        w_ent_live = (e == 0) ? (w_count != 2'd0) : (w_count == 2'd2);
        for (int l = LANES - 1; l >= 0; l--) begin
          w_rec   = (e == 0) ? w_newest[l*REC_W +: REC_W] : w_head[l*REC_W +: REC_W];
          w_match = w_ent_live && !w_bubb && (w_qa != '0) && w_rec[XLEN] &&
                    (w_rec[XLEN + 1 +: RADDR_W] == w_qa);
          fwd_data_o[q*XLEN +: XLEN] = (w_match && !w_found) ? w_rec[XLEN-1:0] :
                                       fwd_data_o[q*XLEN +: XLEN];
          w_found = w_found || w_match;
        end
      end
      fwd_hit_o[q] = w_found;
    end
  end
`endif

endmodule

// File: tb/tb_reg_wb_pipe.sv
// Randomised and directed bench for reg_wb_pipe (LANES=2) against a queue model.
module tb_reg_wb_pipe;
  import pipe_pkg::*;

  localparam int LANES = 2;
  localparam int XW    = 32;
  localparam int RW    = 5;
  localparam int AW    = LANES * RW;
  localparam int DW    = LANES * XW;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    stall;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rd_addr_i;
  logic [LANES-1:0] rd_write_i;
  logic [DW-1:0] rd_data_i;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] rd_addr_o;
  logic [LANES-1:0] rd_write_o;
  logic [DW-1:0] rd_data_o;
  logic [1:0]    occupancy;
`ifdef REG_WB_PIPE_FWD_EN
  logic [AW-1:0] fwd_addr_i;
  logic [LANES-1:0] fwd_hit_o;
  logic [DW-1:0] fwd_data_o;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: beats in push order, already x0-masked.
  logic [AW-1:0]    q_addr[$];
  logic [LANES-1:0] q_wr[$];
  logic [DW-1:0]    q_dat[$];
  bit               p_bubb, p_push, p_pop;
  logic [AW-1:0]    p_a;
  logic [LANES-1:0] p_w;
  logic [DW-1:0]    p_d;

  reg_wb_pipe #(.LANES(LANES), .XLEN(XW), .RADDR_W(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rd_addr_i  (rd_addr_i),
    .rd_write_i (rd_write_i),
    .rd_data_i  (rd_data_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rd_addr_o  (rd_addr_o),
    .rd_write_o (rd_write_o),
    .rd_data_o  (rd_data_o),
    .occupancy  (occupancy)
`ifdef REG_WB_PIPE_FWD_EN
    ,
    .fwd_addr_i (fwd_addr_i),
    .fwd_hit_o  (fwd_hit_o),
    .fwd_data_o (fwd_data_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model for the current inputs.
  task automatic model_check();
    int n;
    n = q_addr.size();
    chk("in_ready",  in_ready,  (n < 2) && (stall == STALL_PASS));
    chk("out_valid", out_valid, (n != 0) && (stall != STALL_BUBB));
    chk("occupancy", occupancy, n);
    chk("rd_addr_o",  rd_addr_o,  (n != 0) ? q_addr[0] : '0);
    chk("rd_write_o", rd_write_o, (n != 0) ? q_wr[0]   : '0);
    chk("rd_data_o",  rd_data_o,  (n != 0) ? q_dat[0]  : '0);
`ifdef REG_WB_PIPE_FWD_EN
    for (int q = 0; q < LANES; q++) begin
      logic [RW-1:0] qa, ea;
      logic [AW-1:0] ta;
      logic [DW-1:0] td;
      logic [LANES-1:0] tw;
      bit h;
      logic [XW-1:0] dd;
      h  = 0;
      dd = '0;
      qa = fwd_addr_i[q*RW +: RW];
      if (stall != STALL_BUBB && qa != '0) begin
        for (int i = n - 1; i >= 0; i--) begin
          ta = q_addr[i];
          tw = q_wr[i];
          td = q_dat[i];
          for (int l = LANES - 1; l >= 0; l--) begin
            ea = ta[l*RW +: RW];
            if (!h && tw[l] && ea == qa) begin
              h  = 1;
              dd = td[l*XW +: XW];
            end
          end
        end
      end
      chk("fwd_hit_o",  fwd_hit_o[q], h);
      chk("fwd_data_o", fwd_data_o[q*XW +: XW], dd);
    end
`endif
  endtask

  // Apply inputs after the falling edge, check, and plan the model update.
  task automatic drive(input logic [1:0] st, input logic iv, input logic ordy,
                       input logic [AW-1:0] a, input logic [LANES-1:0] w, input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    stall = st; in_valid = iv; out_ready = ordy;
    rd_addr_i = a; rd_write_i = w; rd_data_i = d;
    #1;
    model_check();
    n = q_addr.size();
    p_bubb = (st == STALL_BUBB);
    p_push = (st == STALL_PASS) && iv && (n < 2);
    p_pop  = (st == STALL_PASS) && ordy && (n != 0);
    p_a = a; p_w = '0; p_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (a[l*RW +: RW] != '0) begin
        p_w[l] = w[l];
        p_d[l*XW +: XW] = d[l*XW +: XW];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (p_bubb) begin
      q_addr.delete(); q_wr.delete(); q_dat.delete();
    end else begin
      if (p_pop) begin
        void'(q_addr.pop_front()); void'(q_wr.pop_front()); void'(q_dat.pop_front());
      end
      if (p_push) begin
        q_addr.push_back(p_a); q_wr.push_back(p_w); q_dat.push_back(p_d);
      end
    end
    p_bubb = 0; p_push = 0; p_pop = 0;
  endtask

  task automatic idle(input logic [1:0] st, input logic ordy);
    drive(st, 1'b0, ordy, '0, '0, '0);
  endtask

  logic [AW-1:0] ba[3];
  logic [DW-1:0] bd[3];

  initial begin
    rst = 1'b1; stall = STALL_PASS; in_valid = 1'b0; out_ready = 1'b0;
    rd_addr_i = '0; rd_write_i = '0; rd_data_i = '0;
`ifdef REG_WB_PIPE_FWD_EN
    fwd_addr_i = '0;
`endif
    p_bubb = 0; p_push = 0; p_pop = 0;
    for (int i = 0; i < 3; i++) begin
      ba[i] = {RW'(i + 9), RW'(i + 1)};
      bd[i] = {32'hB000_0000 + XW'(i), 32'hA000_0000 + XW'(i)};
    end
    #12 rst = 1'b0;

    // Reset state.
    idle(STALL_PASS, 1'b1);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_data", rd_data_o, 64'h0);
    step();

    // Streaming: one beat per cycle, occupancy stays at 1.
    for (int i = 0; i < 4; i++) begin
      drive(STALL_PASS, 1'b1, 1'b1, {5'd6, 5'd5}, 2'b11, {32'h22, 32'h11});
      if (i > 0) begin
        chk("stream_occ", occupancy, 2'd1);
        chk("stream_addr", rd_addr_o, 10'h0C5);
        chk("stream_data", rd_data_o, 64'h0000_0022_0000_0011);
      end
      step();
    end
    idle(STALL_PASS, 1'b1); step();

    // Back-pressure: third beat held upstream, then in-order drain.
    drive(STALL_PASS, 1'b1, 1'b0, ba[0], 2'b11, bd[0]); step();
    drive(STALL_PASS, 1'b1, 1'b0, ba[1], 2'b11, bd[1]); step();
    drive(STALL_PASS, 1'b1, 1'b0, ba[2], 2'b11, bd[2]);
    chk("bp_ready", in_ready, 1'b0);
    chk("bp_occ", occupancy, 2'd2);
    step();
    drive(STALL_PASS, 1'b1, 1'b1, ba[2], 2'b11, bd[2]);
    chk("bp_head0", rd_addr_o, 10'h121);
    step();
    drive(STALL_PASS, 1'b1, 1'b1, ba[2], 2'b11, bd[2]);
    chk("bp_head1", rd_addr_o, 10'h142);
    step();
    idle(STALL_PASS, 1'b1);
    chk("bp_head2", rd_addr_o, 10'h163);
    chk("bp_occ2", occupancy, 2'd1);
    step();
    idle(STALL_PASS, 1'b1); step();

    // Hold freezes a full buffer; Bubb flushes it and drops the presented beat.
    drive(STALL_PASS, 1'b1, 1'b0, ba[0], 2'b11, bd[0]); step();
    drive(STALL_PASS, 1'b1, 1'b0, ba[1], 2'b11, bd[1]); step();
    for (int i = 0; i < 3; i++) begin
      drive(STALL_HOLD, 1'b1, 1'b1, ba[2], 2'b11, bd[2]);
      chk("hold_occ", occupancy, 2'd2);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_head", rd_addr_o, 10'h121);
      step();
    end
    drive(STALL_BUBB, 1'b1, 1'b1, ba[2], 2'b11, bd[2]);
    chk("bubb_valid", out_valid, 1'b0);
    step();
    idle(STALL_PASS, 1'b1);
    chk("bubb_occ", occupancy, 2'd0);
    chk("bubb_valid2", out_valid, 1'b0);
    step();

    // x0 masking on lane 0.
    drive(STALL_PASS, 1'b1, 1'b1, {5'd3, 5'd0}, 2'b11, {32'h33, 32'hDEAD}); step();
    idle(STALL_PASS, 1'b1);
    chk("x0_write", rd_write_o, 2'b10);
    chk("x0_data", rd_data_o, 64'h0000_0033_0000_0000);
    step();
    idle(STALL_PASS, 1'b1); step();

`ifdef REG_WB_PIPE_FWD_EN
    // Forwarding: newest entry wins, x0 never hits, Bubb suppresses hits.
    drive(STALL_PASS, 1'b1, 1'b0, {5'd0, 5'd7}, 2'b11, {32'h0, 32'hAA}); step();
    drive(STALL_PASS, 1'b1, 1'b0, {5'd0, 5'd7}, 2'b11, {32'h0, 32'hBB}); step();
    fwd_addr_i = {5'd7, 5'd7};
    idle(STALL_PASS, 1'b0);
    chk("fwd_hit", fwd_hit_o, 2'b11);
    chk("fwd_data", fwd_data_o, 64'h0000_00BB_0000_00BB);
    step();
    fwd_addr_i = {5'd0, 5'd7};
    idle(STALL_PASS, 1'b0);
    chk("fwd_x0", fwd_hit_o, 2'b01);
    step();
    fwd_addr_i = {5'd7, 5'd7};
    idle(STALL_BUBB, 1'b0);
    chk("fwd_bubb", fwd_hit_o, 2'b00);
    step();
`endif

    // Asynchronous reset between edges with a full buffer.
    drive(STALL_PASS, 1'b1, 1'b0, ba[0], 2'b11, bd[0]); step();
    drive(STALL_PASS, 1'b1, 1'b0, ba[1], 2'b11, bd[1]); step();
    idle(STALL_PASS, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_occ", occupancy, 2'd0);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_addr", rd_addr_o, 10'h0);
    chk("arst_data", rd_data_o, 64'h0);
    chk("arst_ready", in_ready, 1'b1);
    rst = 1'b0;
    q_addr.delete(); q_wr.delete(); q_dat.delete();
    p_bubb = 0; p_push = 0; p_pop = 0;
    step();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      int r;
      logic [1:0] st;
      logic [AW-1:0] a;
      r  = $urandom_range(0, 11);
      st = (r < 8) ? STALL_PASS : (r == 8) ? STALL_HOLD : (r == 9) ? STALL_BUBB : 2'b11;
      for (int l = 0; l < LANES; l++) a[l*RW +: RW] = RW'($urandom_range(0, 7));
`ifdef REG_WB_PIPE_FWD_EN
      for (int l = 0; l < LANES; l++) fwd_addr_i[l*RW +: RW] = RW'($urandom_range(0, 7));
`endif
      drive(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), a,
            LANES'($urandom), {$urandom, $urandom});
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_pipe.md
Name: reg_wb_pipe

Overview:
- Parametrised successor to the single-lane MEM/WB pipeline register.
- Carries LANES parallel write-back records (rd address, write enable, data) from MEM to the register file.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.
- Keeps the global stall-bus control (Pass/Hold/Bubb) with defined priority over the handshake.

Parameters:
- LANES, 1, number of write-back records per beat (1..4).
- XLEN, 32, data width per lane.
- RADDR_W, 5, register address width per lane.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  STALL_W  stall code from the hazard unit: Pass, Hold or Bubb.
- in_valid  in  1  MEM beat valid.
- in_ready  out  1  stage can accept a beat.
- rd_addr_i  in  LANES*RADDR_W  lane-packed destination addresses; lane 0 is in the LSBs.
- rd_write_i  in  LANES  per-lane write enable.
- rd_data_i  in  LANES*XLEN  per-lane write data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file consumes the head.
- rd_addr_o  out  LANES*RADDR_W  head addresses.
- rd_write_o  out  LANES  head write enables, after x0 masking.
- rd_data_o  out  LANES*XLEN  head data.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage: 2-entry circular buffer with head pointer, tail pointer and a 2-bit count, all registers.
- Reset (asynchronous) clears count, both pointers and all entry fields. Immediately after reset:
  - out_valid = 0
  - rd_*_o = 0
  - occupancy = 0
  - in_ready = 1 when stall == Pass.
- in_ready = (count != 2) && (stall == Pass). Combinational from registered state only.
- out_valid = (count != 0) && (stall != Bubb).
- Outputs when count == 0: rd_addr_o, rd_write_o and rd_data_o are all 0.
- Push = in_valid && in_ready. Pop = out_valid && out_ready && (stall == Pass).
- Stall priority, evaluated each rising edge:
  - Bubb: count <= 0, pointers <= 0, entry fields cleared. Beats presented in this cycle are dropped.
  - Hold: no push, no pop; every register holds its value.
  - Pass: normal handshake.
- Count transitions under Pass:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop together: count unchanged. Only possible when count is 1; at count 0 out_valid = 0, at count 2 in_ready = 0.
- Pointers are 1 bit and toggle on push (tail) or pop (head); wrap is implicit.
- x0 masking: a lane with rd_addr == 0 stores write = 0, and its data is stored as 0.
- Latency: a beat pushed at edge N appears on the outputs after edge N when the buffer was empty (1-cycle register latency). Throughput is 1 beat per cycle while out_ready is held high.
- Order: beats pop in push order. Lanes within a beat are independent and are not reordered.
- Unknown stall codes are treated as Hold.

Optional Feature:
- Macro: REG_WB_PIPE_FWD_EN.
- When defined, adds:
  - Inputs: fwd_addr_i (LANES*RADDR_W), one query per consumer lane.
  - Outputs: fwd_hit_o (LANES) and fwd_data_o (LANES*XLEN).
- Lookup is combinational and searches valid entries in this order: tail-most first, then higher lane index first within an entry. The first match with write = 1 and a nonzero address wins.
- If no entry matches: hit = 0 and data = 0. Queries for address 0 never hit.
- During Bubb, all hits are 0.
- When the macro is not defined, these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - STALL_W (2) and stall codes Pass=2'b00, Hold=2'b01, Bubb=2'b10.
  - wb_rec_t: {addr, write, data} for one lane.
- One natural sub-module, wb_skid2: a generic 2-entry skid buffer parameterised on payload width. reg_wb_pipe adds the stall decoding, x0 masking and forwarding around it.

Test Plan:
- Reset mid-operation: count=2, assert rst asynchronously between edges -> all outputs 0 immediately, occupancy=0.
- Streaming: LANES=2, stall=Pass, out_ready=1. Push {x5,wr,0x11},{x6,wr,0x22} each cycle -> same beat on outputs one cycle later, occupancy stays 1.
- Back-pressure: out_ready=0, push 3 beats -> in_ready drops after 2 accepted. Third beat held upstream, occupancy=2. Raise out_ready -> the three beats come out in order.
- Hold vs Bubb:
  - count=2 with stall=Hold for 3 cycles -> outputs and occupancy frozen, in_ready=0.
  - Then Bubb for 1 cycle -> occupancy=0, out_valid=0, and the in_valid beat presented in that cycle is dropped.
- x0 masking: push {addr=0, write=1, data=0xDEAD} -> rd_write_o=0 and rd_data_o=0 for that lane.
- FWD_EN: entries {x7,0xAA} (older) and {x7,0xBB} (newer), query x7 -> hit=1, data=0xBB. Query x0 -> hit=0. Query during Bubb -> hit=0.
